fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_reader_skid_buf2.sv | 61 ++++++
 rtl/fifo_reader.sv | 125 ++++++++++++
 tb/tb_fifo_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read path: default widths, the burst
// reader state encoding and a small occupancy helper.
package fifo_pkg;

  localparam int DW_DEF = 8;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bytes that will still sit in the output buffer once this cycle's
  // outgoing byte has left and the byte already in flight has landed.
  function automatic logic [2:0] effOccupancy(input logic [1:0] occ,
                                              input logic       pop,
                                              input logic       inFlight);
    return {1'b0, occ} - {2'b00, pop} + {2'b00, inFlight};
  endfunction

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry output buffer between the FIFO read port and the output stream.
// Entries are kept in arrival order; the oldest one is always presented.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_wrEn,
  input  logic [DW-1:0] i_wrData,
  input  logic          i_rdEn,
  output logic [DW-1:0] o_rdData,
  output logic          o_valid,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [0:1];
  logic          r_wrPtr;
  logic          r_rdPtr;
  logic [1:0]    r_count;
  logic          w_pop;

  assign w_pop = i_rdEn && (r_count != 2'd0);

  // Capture incoming bytes into the slot the write pointer selects.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (i_wrEn) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Single-bit pointers wrap modulo 2; count tracks stored bytes.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({i_wrEn, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_valid  = (r_count != 2'd0);
  assign o_count  = r_count;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls LEN bytes out of a FIFO with a one-cycle read latency
// and streams them out through a two-entry buffer with valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  input  logic [LW-1:0] LEN,
  input  logic          EMPTY,
  output logic          REN,
  input  logic [DW-1:0] RDATA,
  output logic [DW-1:0] M_DATA,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic          M_LAST,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [LW:0] CNT_ONE = (LW+1)'(1);

  state_t        r_state;
  state_t        w_nextState;
  logic [LW:0]   r_rdRemain;
  logic [LW:0]   r_outRemain;
  logic          r_inFlight;
  logic          r_done;

  logic [LW:0]   w_lenFull;
  logic          w_bufValid;
  logic [DW-1:0] w_bufData;
  logic [1:0]    w_occ;
  logic          w_pop;
  logic          w_lastHs;
  logic [2:0]    w_effOcc;
  logic          w_ren;
  logic          w_finalRen;

  // A zero length stands for the full 2^LW byte burst.
  assign w_lenFull = (LEN == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, LEN};

  assign w_pop    = w_bufValid && M_READY;
  assign w_lastHs = w_pop && (r_outRemain == CNT_ONE);

  // Counting the byte leaving this cycle lets reads keep pace with a
  // continuously ready consumer while never overfilling the buffer.
  assign w_effOcc   = effOccupancy(w_occ, w_pop, r_inFlight);
  assign w_ren      = (r_state == ST_RUN) && !EMPTY &&
                      (r_rdRemain != '0) && (w_effOcc < 3'd2);
  assign w_finalRen = w_ren && (r_rdRemain == CNT_ONE);

  // State register.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection: accept a burst, stop reading, then wait for the last byte.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:  if (START)      w_nextState = ST_RUN;
      ST_RUN:   if (w_finalRen) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_lastHs)   w_nextState = ST_IDLE;
      default:                  w_nextState = ST_IDLE;
    endcase
  end

  // Burst counters: loaded on acceptance, START is ignored once busy.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      r_rdRemain  <= '0;
      r_outRemain <= '0;
    end else if ((r_state == ST_IDLE) && START) begin
      r_rdRemain  <= w_lenFull;
      r_outRemain <= w_lenFull;
    end else begin
      if (w_ren) begin
        r_rdRemain <= r_rdRemain - CNT_ONE;
      end
      if (w_pop && (r_outRemain != '0)) begin
        r_outRemain <= r_outRemain - CNT_ONE;
      end
    end
  end

  // Remember reads in flight so their data is captured next cycle, and pulse DONE.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      r_inFlight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inFlight <= w_ren;
      r_done     <= (r_state == ST_DRAIN) && w_lastHs;
    end
  end

  skid_buf2 #(
    .DW (DW)
  ) u_skidBuf (
    .i_clock  (CLK),
    .i_reset  (RSTn),
    .i_wrEn   (r_inFlight),
    .i_wrData (RDATA),
    .i_rdEn   (M_READY),
    .o_rdData (w_bufData),
    .o_valid  (w_bufValid),
    .o_count  (w_occ)
  );

  assign REN     = w_ren;
  assign M_DATA  = w_bufData;
  assign M_VALID = w_bufValid;
  assign M_LAST  = w_bufValid && (r_outRemain == CNT_ONE);
  assign BUSY    = (r_state != ST_IDLE);
  assign DONE    = r_done;

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: a FIFO model feeds the DUT, bursts push their
// expected bytes into a scoreboard and a negedge monitor checks the stream.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int DW = DW_DEF;
  localparam int LW = LW_DEF;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          CLK, RSTn, START, EMPTY, REN, M_VALID, M_READY, M_LAST, BUSY, DONE;
  logic [LW-1:0] LEN;
  logic [DW-1:0] RDATA, M_DATA;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] sourceQ[$];
  exp_t          expQ[$];

  int            checks = 0;
  int            errors = 0;
  int            doneCount = 0;
  int            burstHs = 0;
  int            outstanding = 0;
  int            cyc = 0;
  int            prevHsCycle = 0;
  int            readyMode = 0;
  bit            emptyHold = 0;
  bit            randEmpty = 0;
  bit            renLatched = 0;
  bit            streamCheck = 0;
  bit            expectDone = 0;
  bit            prevStall = 0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;
  logic [DW-1:0] nextByte = '0;

  fifo_reader #(.DW(DW), .LW(LW)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .START   (START),
    .LEN     (LEN),
    .EMPTY   (EMPTY),
    .REN     (REN),
    .RDATA   (RDATA),
    .M_DATA  (M_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .M_LAST  (M_LAST),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(nextByte);
      sourceQ.push_back(nextByte);
      nextByte = nextByte + 1'b1;
    end
  endtask

  // Issue a burst once the reader is idle; the next n source bytes become the expectation.
  task automatic applyStimulus(input logic [LW-1:0] len);
    int   n;
    int   budget;
    exp_t e;
    n      = (len == '0) ? (1 << LW) : int'(len);
    budget = 3000;
    @(posedge CLK); #1;
    while (BUSY !== 1'b0 && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("[TB] FAIL start_wait: BUSY stuck at %b, expected 0", BUSY);
    end
    for (int i = 0; i < n; i++) begin
      e.data = (sourceQ.size() > 0) ? sourceQ.pop_front() : '0;
      e.last = (i == n - 1);
      expQ.push_back(e);
    end
    burstHs = 0;
    START   = 1'b1;
    LEN     = len;
    @(posedge CLK); #1;
    START   = 1'b0;
    checkOutput("busy_after_start", BUSY, 1);
  endtask

  // Pulse START while a burst is running; it must be ignored.
  task automatic pokeStart(input logic [LW-1:0] len);
    @(posedge CLK); #1;
    if (BUSY === 1'b1) begin
      START = 1'b1;
      LEN   = len;
      @(posedge CLK); #1;
      START = 1'b0;
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int b;
    b = budget;
    do begin
      @(negedge CLK); #1;
      b--;
    end while ((expQ.size() != 0 || BUSY !== 1'b0) && b > 0);
    if (b == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: %0d bytes outstanding, expected 0", name, expQ.size());
    end
    repeat (2) @(negedge CLK);
    #1;
  endtask

  // FIFO model: pops on the edge after a REN cycle and drives ready/empty patterns.
  initial begin
    RDATA   = '0;
    EMPTY   = 1'b1;
    M_READY = 1'b1;
    forever begin
      @(negedge CLK);
      renLatched = (REN === 1'b1);
      @(posedge CLK); #1;
      if (renLatched) begin
        RDATA = (fifoQ.size() > 0) ? fifoQ.pop_front() : {DW{1'b1}};
      end
      if (readyMode == 0)      M_READY = 1'b1;
      else if (readyMode == 1) M_READY = ~M_READY;
      else                     M_READY = 1'($urandom_range(0, 1));
      EMPTY = (fifoQ.size() == 0) || emptyHold ||
              (randEmpty && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: scoreboard on handshakes, DONE timing, stall stability, underflow, occupancy.
  initial forever begin
    exp_t e;
    bit   hs;
    @(negedge CLK);
    if (RSTn === 1'b1) begin
      checkOutput("done_in_reset", DONE, 0);
      expectDone  = 0;
      prevStall   = 0;
      outstanding = 0;
    end else begin
      if (REN === 1'b1) checkOutput("ren_while_empty", EMPTY, 0);
      checkOutput("occupancy_le2", (outstanding <= 2), 1);
      checkOutput("done_pulse", DONE, expectDone);
      if (expectDone) begin
        checkOutput("busy_low_at_done", BUSY, 0);
        doneCount++;
      end
      expectDone = 0;
      if (prevStall) begin
        checkOutput("stall_valid", M_VALID, 1);
        checkOutput("stall_data", M_DATA, prevData);
        checkOutput("stall_last", M_LAST, prevLast);
      end
      hs        = (M_VALID === 1'b1) && (M_READY === 1'b1);
      prevStall = (M_VALID === 1'b1) && (M_READY === 1'b0);
      prevData  = M_DATA;
      prevLast  = M_LAST;
      if (hs) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no output", M_DATA);
        end else begin
          e = expQ.pop_front();
          checkOutput("m_data", M_DATA, e.data);
          checkOutput("m_last", M_LAST, e.last);
          if (e.last) expectDone = 1;
        end
        if (streamCheck && burstHs > 0) checkOutput("stream_gap", cyc - prevHsCycle, 1);
        prevHsCycle = cyc;
        burstHs++;
      end
      outstanding = outstanding + ((REN === 1'b1) ? 1 : 0) - (hs ? 1 : 0);
    end
  end

  initial begin
    int d0;
    int b;
    int len;
    RSTn  = 1'b1;
    START = 1'b0;
    LEN   = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_ren", REN, 0);
    checkOutput("reset_valid", M_VALID, 0);
    checkOutput("reset_last", M_LAST, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_done", DONE, 0);
    checkOutput("reset_data", M_DATA, 0);
    RSTn = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      checkOutput("ren_idle_after_reset", REN, 0);
    end

    // Single LEN=8 burst streaming at full rate
    $display("[TB] single burst LEN=8");
    readyMode = 0; nextByte = '0; streamCheck = 1;
    preload(8);
    d0 = doneCount;
    applyStimulus(8);
    waitIdle("single", 200);
    checkOutput("single_bytes", burstHs, 8);
    checkOutput("single_done_count", doneCount - d0, 1);

    // START during a running burst is ignored
    $display("[TB] START ignored while busy");
    preload(8);
    d0 = doneCount;
    applyStimulus(8);
    pokeStart(3);
    waitIdle("ignored_start", 200);
    checkOutput("ignored_start_bytes", burstHs, 8);
    checkOutput("ignored_start_done", doneCount - d0, 1);

    // Three back-to-back bursts
    $display("[TB] back-to-back bursts");
    fifoQ.delete(); sourceQ.delete(); nextByte = '0;
    preload(24);
    d0 = doneCount;
    repeat (3) applyStimulus(8);
    waitIdle("b2b", 300);
    checkOutput("b2b_done_count", doneCount - d0, 3);

    // Ready toggling every cycle
    $display("[TB] ready toggling LEN=4");
    readyMode = 1; streamCheck = 0;
    preload(4);
    applyStimulus(4);
    waitIdle("toggle", 200);
    checkOutput("toggle_bytes", burstHs, 4);

    // EMPTY gap mid-burst
    $display("[TB] empty gap LEN=6");
    readyMode = 0;
    preload(6);
    applyStimulus(6);
    b = 100;
    while (burstHs < 2 && b > 0) begin
      @(negedge CLK); #1;
      b--;
    end
    checkOutput("gap_reached_byte2", (burstHs >= 2), 1);
    emptyHold = 1;
    @(posedge CLK); #2;
    repeat (5) begin
      checkOutput("ren_during_gap", REN, 0);
      @(posedge CLK); #2;
    end
    emptyHold = 0;
    waitIdle("gap", 200);
    checkOutput("gap_bytes", burstHs, 6);

    // LEN=0 means a full 256-byte burst
    $display("[TB] LEN=0 full burst");
    streamCheck = 1;
    preload(256);
    applyStimulus(0);
    waitIdle("len0", 2000);
    checkOutput("len0_bytes", burstHs, 256);

    // Reset mid-burst aborts without DONE
    $display("[TB] reset mid-burst");
    preload(8);
    applyStimulus(8);
    b = 100;
    while (burstHs < 3 && b > 0) begin
      @(negedge CLK); #1;
      b--;
    end
    checkOutput("abort_reached_byte3", (burstHs >= 3), 1);
    @(posedge CLK); #3;
    RSTn = 1'b1;
    #1;
    d0 = doneCount;
    checkOutput("abort_ren", REN, 0);
    checkOutput("abort_valid", M_VALID, 0);
    checkOutput("abort_last", M_LAST, 0);
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_done", DONE, 0);
    checkOutput("abort_data", M_DATA, 0);
    repeat (3) @(posedge CLK);
    expQ.delete(); fifoQ.delete(); sourceQ.delete();
    #1;
    RSTn = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      checkOutput("ren_after_release", REN, 0);
      checkOutput("no_done_after_abort", doneCount - d0, 0);
    end
    nextByte = 8'h40;
    preload(8);
    applyStimulus(8);
    waitIdle("after_abort", 200);
    checkOutput("after_abort_bytes", burstHs, 8);
    checkOutput("after_abort_done", doneCount - d0, 1);

    // Randomized bursts with random ready and empty spikes
    $display("[TB] randomized bursts");
    readyMode = 2; randEmpty = 1; streamCheck = 0;
    d0 = doneCount;
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(1, 20);
      preload(len + $urandom_range(0, 3));
      applyStimulus(LW'(len));
      if ($urandom_range(0, 2) == 0) pokeStart(LW'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) waitIdle("random", 1000);
    end
    waitIdle("random_end", 1000);
    checkOutput("random_done_count", doneCount - d0, 25);
    readyMode = 0; randEmpty = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
